explode_write_arbiter: RTL
==========================

EXPLODE_WRITE_ARBITER -- requirements
Module: explode_write_arbiter

Interface
REQ-001 Parameter NUM_ENGINES, default 2, number of explode engines sharing one scratchpad write port.
REQ-002 Parameter ADDR_W, default 32, byte-address width of the write port.
REQ-003 Parameter BURST_LEN, default 8, beats per grant (one 128-byte scratchpad line).
REQ-004 clk  input  1  clock; rstn  input  1  synchronous, active-low reset.
REQ-005 eng_req  input  NUM_ENGINES  per-engine request_write.
REQ-006 eng_data  input  NUM_ENGINES*128  per-engine scratch_write, engine k at bits [128k+127:128k].
REQ-007 eng_addr  input  NUM_ENGINES*32  per-engine mem_address (128-bit word index).
REQ-008 eng_done  input  NUM_ENGINES  per-engine done.
REQ-009 base_addr  input  NUM_ENGINES*ADDR_W  per-engine scratchpad byte base, static while busy.
REQ-010 eng_full  output  NUM_ENGINES  per-engine i_buffer_full (stall).
REQ-011 w_valid  output  1; w_ready  input  1; w_data  output  128; w_addr  output  ADDR_W; w_id  output  clog2(NUM_ENGINES) (min 1).
REQ-012 busy  output  1  high while state is BURST or w_valid is high.

Function
REQ-013 States: IDLE, BURST; reset state IDLE.
REQ-014 can_accept = ~w_valid | w_ready.
REQ-015 eng_full[k] = 0 when ~eng_req[k] (engine in preliminary rounds or done runs freely).
REQ-016 eng_full[k] = ~(state==BURST & grant==k & can_accept) when eng_req[k].
REQ-017 IDLE: if any eng_req high and eng_done low, grant the first such engine in round-robin order starting at last_grant+1 (mod NUM_ENGINES), go BURST, beat counter = 0; no beat transferred in the IDLE cycle.
REQ-018 IDLE with no eligible request: remain IDLE, grant unchanged.
REQ-019 BURST beat: when eng_req[grant] & can_accept, register w_data = eng_data[grant], w_addr = base_addr[grant] + (eng_addr[grant] << 4) truncated to ADDR_W, w_id = grant, w_valid = 1; beat counter +1.
REQ-020 Output latency: one cycle from engine beat to w_valid; w_data/w_addr/w_id stable while w_valid & ~w_ready.
REQ-021 w_valid clears on w_ready when no new beat is loaded the same cycle; simultaneous accept and load keeps w_valid high with new data.
REQ-022 BURST exits to IDLE after the BURST_LEN-th loaded beat, or when eng_req[grant] is low or eng_done[grant] high; last_grant = grant on exit.
REQ-023 A granted engine that drops eng_req mid-burst releases the port; partial bursts are legal.
REQ-024 w_ready low with w_valid high: all requesting engines stalled, beat counter frozen, no beat lost or duplicated.
REQ-025 Non-granted engines never have a beat loaded; every engine write appears on w_* exactly once.
REQ-026 NUM_ENGINES = 1: round-robin degenerates to always granting engine 0.

Reset
REQ-027 rstn low: state IDLE, grant 0, last_grant NUM_ENGINES-1, beat counter 0, w_valid 0, w_data 0, w_addr 0, w_id 0, busy 0.
REQ-028 eng_full is combinational; during reset it evaluates to 1 for requesting engines, 0 otherwise.
REQ-029 Reset mid-burst discards any held beat; no partial transfer completes after reset.

Structure
REQ-030 Shared package holds BURST_LEN default, the 128-bit word width, the word-to-byte shift (4) and the state encoding.
REQ-031 One sub-module is natural: rr_arbiter (combinational round-robin pick from request vector and last_grant).

Verification
REQ-032 Single engine, eng_req high 8 cycles, eng_addr 0..7, base 0x1000, w_ready=1 -> 8 beats, w_addr 0x1000..0x1070, w_id 0, then IDLE.
REQ-033 Both engines requesting continuously, w_ready=1 -> bursts alternate 0,1,0,1 each 8 beats, one IDLE cycle between bursts.
REQ-034 w_ready low 5 cycles at beat 3 -> w_data/w_addr held constant, eng_full[grant]=1, beat 3 appears once, bursts complete with 8 beats.
REQ-035 Engine 1 in preliminary (eng_req=0) while engine 0 bursts -> eng_full[1]=0 throughout, engine 0 unaffected.
REQ-036 Granted engine raises eng_done after beat 5 -> burst ends with 6 beats, grant moves to engine 1 after one IDLE cycle.
REQ-037 rstn low at beat 4 with w_valid high -> next cycle w_valid=0, state IDLE, busy=0.

Source files
------------

// File: rtl/explode_write_arbiter_pkg.sv
// Shared definitions for the explode write arbiter.
//   BURST_LEN_DEFAULT : beats per grant (one 128-byte scratchpad line)
//   WORD_W            : scratchpad word width in bits
//   WORD_SHIFT        : word-index to byte-address shift
//   ENG_ADDR_W        : width of an engine's word-index address
//   state_e           : arbiter FSM state encoding
package explode_write_arbiter_pkg;

    localparam int unsigned BURST_LEN_DEFAULT = 8;
    localparam int unsigned WORD_W            = 128;
    localparam int unsigned WORD_SHIFT        = 4;
    localparam int unsigned ENG_ADDR_W        = 32;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StBurst = 1'b1
    } state_e;

    // Engine-id width; a single engine still gets a 1-bit id.
    function automatic int unsigned id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/explode_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   i_req   : eligible request vector
//   i_last  : engine granted most recently
//   o_valid : at least one eligible request
//   o_grant : first requester found searching from i_last+1 (mod NUM_ENGINES)
module explode_write_arbiter_rr_arbiter
    import explode_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_ENGINES = 2,
    parameter int unsigned ID_W        = 1
) (
    input  logic [NUM_ENGINES-1:0] i_req,
    input  logic [ID_W-1:0]        i_last,
    output logic                   o_valid,
    output logic [ID_W-1:0]        o_grant
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_cand  = i_last;
        for (int unsigned step = 0; step < NUM_ENGINES; step++) begin
            w_cand = (32'(w_cand) == NUM_ENGINES - 1) ? '0 : w_cand + 1'b1;
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_grant = w_cand;
            end
        end
    end

endmodule

// File: rtl/explode_write_arbiter.sv
// Shares one scratchpad write port between NUM_ENGINES explode engines.
// A granted engine streams up to BURST_LEN beats; the port is registered, so
// each accepted engine beat appears on w_* one cycle later.
//   clk, rstn   : clock, synchronous active-low reset
//   eng_req     : per-engine write request
//   eng_data    : per-engine 128-bit write data (engine k at [128k +: 128])
//   eng_addr    : per-engine 128-bit word index (engine k at [32k +: 32])
//   eng_done    : per-engine done (not eligible for a new grant)
//   base_addr   : per-engine scratchpad byte base
//   eng_full    : per-engine stall (combinational)
//   w_valid/w_ready/w_data/w_addr/w_id : scratchpad write port
//   busy        : burst in progress or beat pending on the port
module explode_write_arbiter
    import explode_write_arbiter_pkg::*;
#(
    parameter int unsigned NUM_ENGINES = 2,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned BURST_LEN   = BURST_LEN_DEFAULT
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic [NUM_ENGINES-1:0]             eng_req,
    input  logic [NUM_ENGINES*WORD_W-1:0]      eng_data,
    input  logic [NUM_ENGINES*ENG_ADDR_W-1:0]  eng_addr,
    input  logic [NUM_ENGINES-1:0]             eng_done,
    input  logic [NUM_ENGINES*ADDR_W-1:0]      base_addr,
    output logic [NUM_ENGINES-1:0]             eng_full,
    output logic                               w_valid,
    input  logic                               w_ready,
    output logic [WORD_W-1:0]                  w_data,
    output logic [ADDR_W-1:0]                  w_addr,
    output logic [id_width(NUM_ENGINES)-1:0]   w_id,
    output logic                               busy
);

    localparam int unsigned ID_W  = id_width(NUM_ENGINES);
    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    state_e            r_state, w_state_next;
    logic [ID_W-1:0]   r_grant, w_grant_next;
    logic [ID_W-1:0]   r_last_grant, w_last_grant_next;
    logic [CNT_W-1:0]  r_beat_cnt, w_beat_cnt_next;
    logic              r_valid;
    logic [WORD_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id;

    logic                  w_rr_valid;
    logic [ID_W-1:0]       w_rr_grant;
    logic                  w_can_accept;
    logic                  w_load;
    logic                  w_last_beat;
    logic                  w_sel_req;
    logic                  w_sel_done;
    logic [WORD_W-1:0]     w_sel_data;
    logic [ENG_ADDR_W-1:0] w_sel_addr;
    logic [ADDR_W-1:0]     w_sel_base;
    logic [ADDR_W-1:0]     w_beat_addr;

    explode_write_arbiter_rr_arbiter #(
        .NUM_ENGINES (NUM_ENGINES),
        .ID_W        (ID_W)
    ) u_rr_arbiter (
        .i_req   (eng_req & ~eng_done),
        .i_last  (r_last_grant),
        .o_valid (w_rr_valid),
        .o_grant (w_rr_grant)
    );

    // Mux the granted engine's signals.
    always_comb begin
        w_sel_req  = 1'b0;
        w_sel_done = 1'b0;
        w_sel_data = '0;
        w_sel_addr = '0;
        w_sel_base = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            if (r_grant == ID_W'(k)) begin
                w_sel_req  = eng_req[k];
                w_sel_done = eng_done[k];
                w_sel_data = eng_data[k*WORD_W +: WORD_W];
                w_sel_addr = eng_addr[k*ENG_ADDR_W +: ENG_ADDR_W];
                w_sel_base = base_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign w_beat_addr  = w_sel_base + ADDR_W'({w_sel_addr, {WORD_SHIFT{1'b0}}});
    assign w_can_accept = ~r_valid | w_ready;
    assign w_load       = (r_state == StBurst) & w_sel_req & w_can_accept;
    assign w_last_beat  = (r_beat_cnt == CNT_W'(BURST_LEN - 1));

    // Only the granted engine with room on the port runs; everyone else that
    // requests is held off. Reset forces every requester to stall.
    always_comb begin
        eng_full = '0;
        for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
            eng_full[k] = eng_req[k] &
                          (~rstn | ~((r_state == StBurst) & (r_grant == ID_W'(k)) &
                                     w_can_accept));
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        w_beat_cnt_next   = r_beat_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_rr_valid) begin
                    w_state_next    = StBurst;
                    w_grant_next    = w_rr_grant;
                    w_beat_cnt_next = '0;
                end
            end
            StBurst: begin
                if (w_load) begin
                    w_beat_cnt_next = r_beat_cnt + 1'b1;
                end
                // A beat offered together with done is still loaded, then the port is released.
                if ((w_load & w_last_beat) | ~w_sel_req | w_sel_done) begin
                    w_state_next      = StIdle;
                    w_last_grant_next = r_grant;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_ENGINES - 1);
            r_beat_cnt   <= '0;
            r_valid      <= 1'b0;
            r_data       <= '0;
            r_addr       <= '0;
            r_id         <= '0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
            r_beat_cnt   <= w_beat_cnt_next;
            if (w_load) begin
                r_valid <= 1'b1;
                r_data  <= w_sel_data;
                r_addr  <= w_beat_addr;
                r_id    <= r_grant;
            end else if (w_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign w_valid = r_valid;
    assign w_data  = r_data;
    assign w_addr  = r_addr;
    assign w_id    = r_id;
    assign busy    = (r_state == StBurst) | r_valid;

endmodule
